// File: rtl/rr_mux_arb_pkg.sv
// Shared types and default sizing for the round-robin mux arbiter.
package rr_mux_arb_pkg;

  localparam int unsigned N_DEF         = 4;
  localparam int unsigned W_DEF         = 8;
  localparam int unsigned MAX_BEATS_DEF = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot winner is the first request at or
// above ptr, wrapping from N-1 back to 0.
module rr_pick
  import rr_mux_arb_pkg::*;
#(
  parameter int unsigned N  = N_DEF,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  win
);

  logic found;

  // First pass covers [ptr, N-1]; second pass wraps to [0, ptr-1].
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= 32'(ptr))) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[i]) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin packet arbiter muxing N requesters onto one valid/ready channel.
// Define RR_MUX_ARB_BEATLIMIT_EN to cap grants at MAX_BEATS beats with an err pulse.
module rr_mux_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int unsigned N         = N_DEF,
  parameter int unsigned W         = W_DEF,
  parameter int unsigned MAX_BEATS = MAX_BEATS_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   last,
  input  logic [N*W-1:0] data_in,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   gnt,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic           err
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || N > 8 || MAX_BEATS < 1) begin : g_bad_param
    $error("rr_mux_arbiter: N must be 2..8 and MAX_BEATS at least 1");
  end

  state_e        state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d, pick;
  logic [PW-1:0] ptr_q, ptr_d, gidx;
  logic          xfer, rel;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (pick)
  );

  // Channel side is purely combinational off the registered grant.
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_q[i]) out_data = out_data | data_in[i*W +: W];
    end
  end

  assign out_last  = |(gnt_q & last);
  assign out_valid = |(gnt_q & req);
  assign ack       = gnt_q & req & {N{out_ready}};
  assign xfer      = |ack;
  assign gnt       = gnt_q;

  always_comb begin
    gidx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_q[i]) gidx = PW'(i);
    end
  end

`ifdef RR_MUX_ARB_BEATLIMIT_EN
  localparam int unsigned BW = $clog2(MAX_BEATS + 1);

  logic [BW-1:0] beat_q, beat_d;
  logic          err_q, err_d;

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    rel     = 1'b0;
`ifdef RR_MUX_ARB_BEATLIMIT_EN
    beat_d  = beat_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = pick;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (out_last) begin
            rel = 1'b1;
          end
`ifdef RR_MUX_ARB_BEATLIMIT_EN
          else if (beat_q == BW'(MAX_BEATS - 1)) begin
            rel   = 1'b1;
            err_d = 1'b1;
          end
          beat_d = beat_q + BW'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
    // Release always passes through IDLE and advances the pointer past the winner.
    if (rel) begin
      state_d = IDLE;
      gnt_d   = '0;
      ptr_d   = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
`ifdef RR_MUX_ARB_BEATLIMIT_EN
      beat_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
`ifdef RR_MUX_ARB_BEATLIMIT_EN
      beat_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
`ifdef RR_MUX_ARB_BEATLIMIT_EN
      beat_q  <= beat_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter; accepted beats are checked against a queue
// of expected beats filled as stimulus is driven.
module tb_rr_mux_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req, last, ack, gnt;
  logic [N*W-1:0] data_in;
  logic           out_valid, out_ready, out_last, err;
  logic [W-1:0]   out_data;

  typedef struct {
    int unsigned  idx;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       mon_e;
  int unsigned errors  = 0;
  int unsigned checks  = 0;
  int unsigned ack_cnt = 0;

  rr_mux_arbiter #(.N(N), .W(W), .MAX_BEATS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .data_in   (data_in),
    .ack       (ack),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int unsigned i, input logic [W-1:0] v);
    data_in[i*W +: W] = v;
  endtask

  task automatic push(input int unsigned i, input logic [W-1:0] v, input logic l);
    exp_q.push_back('{idx: i, data: v, last: l});
  endtask

  // Scoreboard: every accepted beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (ack !== '0) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 32'(ack), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_onehot", 32'(ack), 32'(1) << mon_e.idx);
        chk("beat_data", 32'(out_data), 32'(mon_e.data));
        chk("beat_last", 32'(out_last), 32'(mon_e.last));
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; last = '0; data_in = '0; out_ready = 1'b0;
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Single-beat packet from requester 0.
    req = 4'b0001; last = 4'b0001; set_d(0, 8'hA1); out_ready = 1'b1;
    push(0, 8'hA1, 1'b1);
    #1;
    chk("lat_gnt", 32'(gnt), 32'd0);
    tick();
    chk("s_gnt", 32'(gnt), 32'h1);
    chk("s_valid", 32'(out_valid), 32'd1);
    chk("s_data", 32'(out_data), 32'hA1);
    tick();
    chk("s_rel", 32'(gnt), 32'd0);
    req = '0; last = '0;
    chk("s_acks", ack_cnt, 32'd1);

    // Fair rotation with everyone requesting, starting from a fresh pointer.
    rst_n = 1'b0; #1; rst_n = 1'b1;
    data_in = 32'h13121110; req = 4'b1111; last = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      push(k % 4, 8'(8'h10 + k % 4), 1'b1);
      tick();
      chk("rr_gnt", 32'(gnt), 32'(1) << (k % 4));
      tick();
      chk("rr_idle", 32'(gnt), 32'd0);
    end
    req = '0; last = '0;
    chk("rr_acks", ack_cnt, 32'd6);

    // Three-beat packet from requester 2 with two backpressure cycles.
    data_in = '0; req = 4'b0100; last = '0; set_d(2, 8'hB0);
    push(2, 8'hB0, 1'b0); push(2, 8'hB1, 1'b0); push(2, 8'hB2, 1'b1);
    tick();
    chk("bp_gnt", 32'(gnt), 32'h4);
    tick();
    set_d(2, 8'hB1); out_ready = 1'b0;
    #1;
    chk("bp_ack0", 32'(ack), 32'd0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_data0", 32'(out_data), 32'hB1);
    tick();
    chk("bp_data1", 32'(out_data), 32'hB1);
    chk("bp_ack1", 32'(ack), 32'd0);
    chk("bp_hold", 32'(gnt), 32'h4);
    tick();
    out_ready = 1'b1;
    #1;
    chk("bp_ack2", 32'(ack), 32'h4);
    tick();
    set_d(2, 8'hB2); last = 4'b0100;
    tick();
    chk("bp_rel", 32'(gnt), 32'd0);
    req = '0; last = '0;
    chk("bp_acks", ack_cnt, 32'd9);

    // Asynchronous reset in the middle of a packet from requester 1.
    out_ready = 1'b0; req = 4'b0010; set_d(1, 8'hC0);
    tick();
    chk("ar_gnt", 32'(gnt), 32'h2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt0", 32'(gnt), 32'd0);
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_ack", 32'(ack), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    tick();
    chk("ar_hold", 32'(gnt), 32'd0);
    rst_n = 1'b1; req = 4'b1000; last = 4'b1000; set_d(3, 8'hD3); out_ready = 1'b1;
    push(3, 8'hD3, 1'b1);
    tick();
    chk("ar_regnt", 32'(gnt), 32'h8);
    tick();
    chk("ar_rel", 32'(gnt), 32'd0);
    req = '0; last = '0;
    chk("ar_acks", ack_cnt, 32'd10);

    // Requester 1 streams beats without last while requester 2 waits.
    data_in = '0; req = 4'b0110; last = 4'b0100; set_d(2, 8'hF2);
    tick();
    chk("bl_first", 32'(gnt), 32'h2);
    for (int b = 0; b < 4; b++) begin
      set_d(1, 8'(8'hE0 + b));
      push(1, 8'(8'hE0 + b), 1'b0);
      chk("bl_gnt", 32'(gnt), 32'h2);
      chk("bl_err", 32'(err), 32'd0);
      tick();
    end
`ifdef RR_MUX_ARB_BEATLIMIT_EN
    chk("bl_forced", 32'(gnt), 32'd0);
    chk("bl_errpulse", 32'(err), 32'd1);
    push(2, 8'hF2, 1'b1);
    tick();
    chk("bl_errclr", 32'(err), 32'd0);
    chk("bl_next", 32'(gnt), 32'h4);
    tick();
    chk("bl_done", 32'(gnt), 32'd0);
    req = '0; last = '0;
    chk("bl_acks", ack_cnt, 32'd15);
`else
    for (int b = 4; b < 6; b++) begin
      set_d(1, 8'(8'hE0 + b));
      push(1, 8'(8'hE0 + b), 1'b0);
      chk("ul_gnt", 32'(gnt), 32'h2);
      chk("ul_err", 32'(err), 32'd0);
      tick();
    end
    set_d(1, 8'hE6); last = 4'b0110;
    push(1, 8'hE6, 1'b1);
    chk("ul_held", 32'(gnt), 32'h2);
    tick();
    chk("ul_rel", 32'(gnt), 32'd0);
    chk("ul_err_end", 32'(err), 32'd0);
    push(2, 8'hF2, 1'b1);
    tick();
    chk("ul_next", 32'(gnt), 32'h4);
    tick();
    chk("ul_done", 32'(gnt), 32'd0);
    req = '0; last = '0;
    chk("ul_acks", ack_cnt, 32'd18);
`endif
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter W, default 8, meaning data width per requester.
REQ-003 SHALL have parameter MAX_BEATS, default 16, meaning beat limit per grant (used only under REQ-030).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-006 SHALL have port req, input, N, meaning per-requester request; held high for the whole packet.
REQ-007 SHALL have port last, input, N, meaning per-requester end-of-packet flag, valid with req.
REQ-008 SHALL have port data_in, input, N*W, meaning packed requester data; requester i uses bits [i*W +: W].
REQ-009 SHALL have port ack, output, N, meaning one-hot beat accepted for requester i this cycle.
REQ-010 SHALL have port gnt, output, N, meaning registered one-hot grant.
REQ-011 SHALL have port out_valid, output, 1, meaning shared channel beat valid.
REQ-012 SHALL have port out_ready, input, 1, meaning shared channel sink ready.
REQ-013 SHALL have port out_data, output, W, meaning muxed data of the granted requester.
REQ-014 SHALL have port out_last, output, 1, meaning muxed last of the granted requester.
REQ-015 SHALL have port err, output, 1, meaning one-cycle pulse on forced release.

Function
REQ-016 SHALL implement FSM with states IDLE and GRANT.
REQ-017 SHALL, in IDLE with any req high, select winner by round-robin from pointer ptr (first req at or above ptr, wrapping at N-1 to 0), enter GRANT and assert gnt for the winner on the next edge (1-cycle grant latency).
REQ-018 SHALL, in IDLE with req all zero, stay in IDLE with gnt = 0.
REQ-019 SHALL drive out_valid = |(gnt & req), and route out_data/out_last from the granted requester combinationally; out_data = 0 and out_last = 0 when gnt = 0.
REQ-020 SHALL assert ack[i] = gnt[i] & req[i] & out_ready; a beat transfers exactly when ack is high.
REQ-021 SHALL, on a transfer with last high, return to IDLE on the next edge, clear gnt, and set ptr = winner+1 modulo N.
REQ-022 SHALL, in GRANT, ignore req changes of non-granted requesters; if the granted requester drops req without last, hold the grant and stall (out_valid = 0).
REQ-023 SHALL not allow a new grant in the same cycle a grant is released; IDLE always occupies at least one cycle between grants.
REQ-024 SHALL guarantee every continuously-requesting requester is granted within N grant periods.

Reset
REQ-025 SHALL, while rst_n is low, force state = IDLE, ptr = 0, gnt = 0, beat counter = 0, err = 0, independent of clk.
REQ-026 SHALL, on reset mid-packet, abandon the packet with no ack and no err; after release, arbitration restarts from requester 0.
REQ-027 SHALL hold ack = 0 and out_valid = 0 during reset.

Configuration
REQ-028 SHALL use macro RR_MUX_ARB_BEATLIMIT_EN.
REQ-029 SHALL, without the macro, omit the beat counter, allow unlimited grant length, and tie err to 0.
REQ-030 SHALL, with the macro defined, count transfers in GRANT; a transfer that is the MAX_BEATS-th without last forces release as in REQ-021 and pulses err for one cycle on the next edge.

Structure
REQ-031 SHALL place the state enum (IDLE, GRANT) and default parameter constants in package rr_mux_arb_pkg.
REQ-032 SHALL implement the round-robin winner selection as sub-module rr_pick (inputs req, ptr; output one-hot winner), combinational.

Verification
REQ-033 SHALL test: reset, then req=4'b0001, last high, out_ready=1 -> gnt=0001 after one edge, one ack pulse, gnt=0 next edge.
REQ-034 SHALL test: req=4'b1111 constant, single-beat packets -> grant order 0,1,2,3,0 with an IDLE cycle between each.
REQ-035 SHALL test: granted requester 2 sends 3 beats, out_ready low on beat 2 for 2 cycles -> out_data holds beat 2, ack only on ready cycles, exactly 3 acks.
REQ-036 SHALL test: rst_n low mid-packet asynchronously -> gnt=0, out_valid=0 immediately; after release with req=4'b1000 -> grant to 3.
REQ-037 SHALL test, macro defined, MAX_BEATS=4: requester 1 streams 6 beats without last -> release after 4th ack, err pulses once, next grant goes to requester 2 if requesting.
REQ-038 SHALL test, macro undefined: same stimulus -> grant held for all 6 beats, err stays 0.
